// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues data-memory strobes, stalls the pipeline while an
// access is outstanding, and traps on misalignment, memory errors, timeout or HALT.
module mem_stage_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        DMemEn_in,
    input  logic        MemWrite_in,
    input  logic        DMemDump_in,
    input  logic [15:0] aluOutput_in,
    input  logic [15:0] writeData_in,
    output logic [15:0] mem_Addr,
    output logic [15:0] mem_DataIn,
    output logic        mem_Rd,
    output logic        mem_Wr,
    output logic        mem_createdump,
    input  logic [15:0] mem_DataOut,
    input  logic        mem_Done,
    input  logic        mem_err,
    output logic [15:0] readData_out,
    output logic        memStall,
    output logic        latch_en,
    output logic        err,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {IDLE, WAIT, HALT, ERR} state_t;

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [7:0]  wd_q, wd_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] rd_q, rd_d;
    logic        req;
    logic        load_done;

    assign mem_Addr    = aluOutput_in;
    assign mem_DataIn  = writeData_in;
    assign latch_en    = ~memStall;
    assign err         = err_q;
    assign stall_count = cnt_q;

    always_comb begin
        state_d        = state_q;
        wr_d           = wr_q;
        wd_d           = wd_q;
        err_d          = err_q;
        mem_Rd         = 1'b0;
        mem_Wr         = 1'b0;
        mem_createdump = 1'b0;
        memStall       = 1'b0;
        load_done      = 1'b0;
        req            = valid_in & DMemEn_in & ~DMemDump_in;

        case (state_q)
            IDLE: begin
                if (valid_in && DMemDump_in) begin
                    mem_createdump = 1'b1;
                    state_d        = HALT;
                end else if (req) begin
                    memStall = ~mem_Done;
                    if (aluOutput_in[0]) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else begin
                        mem_Rd = ~MemWrite_in;
                        mem_Wr = MemWrite_in;
                        if (mem_err) begin
                            err_d   = 1'b1;
                            state_d = ERR;
                        end else if (mem_Done) begin
                            load_done = ~MemWrite_in;
                        end else begin
                            state_d = WAIT;
                            wr_d    = MemWrite_in;
                            wd_d    = 8'd0;
                        end
                    end
                end
            end
            WAIT: begin
                // Direction is latched at issue; address/data come from the frozen EX/MEM latch.
                mem_Rd   = ~wr_q;
                mem_Wr   = wr_q;
                memStall = ~mem_Done;
                if (mem_err) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end else if (mem_Done) begin
                    load_done = ~wr_q;
                    state_d   = IDLE;
                end else if (wd_q == 8'd254) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            default: memStall = 1'b1;
        endcase

        if (rst) begin
            mem_Rd         = 1'b0;
            mem_Wr         = 1'b0;
            mem_createdump = 1'b0;
            memStall       = 1'b0;
            load_done      = 1'b0;
        end

        readData_out = load_done ? mem_DataOut : rd_q;
        rd_d         = readData_out;
        cnt_d        = (memStall && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

        if (rst) begin
            state_d = IDLE;
            wr_d    = 1'b0;
            wd_d    = 8'd0;
            err_d   = 1'b0;
            cnt_d   = 16'd0;
            rd_d    = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        wr_q    <= wr_d;
        wd_q    <= wd_d;
        err_q   <= err_d;
        cnt_q   <= cnt_d;
        rd_q    <= rd_d;
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst, valid_in, DMemEn_in, MemWrite_in, DMemDump_in;
    logic [15:0] aluOutput_in, writeData_in, mem_DataOut;
    logic        mem_Done, mem_err;
    logic [15:0] mem_Addr, mem_DataIn, readData_out, stall_count;
    logic        mem_Rd, mem_Wr, mem_createdump, memStall, latch_en, err;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: an access is "busy" for some number of waited cycles;
    // "dead" covers both HALT and the error trap.
    bit       m_busy, m_dead, m_pw, m_err;
    int       m_waited;
    int       m_cnt;
    bit [15:0] m_rdreg;

    always #5 clk = ~clk;

    mem_stage_ctrl dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .DMemEn_in(DMemEn_in),
        .MemWrite_in(MemWrite_in), .DMemDump_in(DMemDump_in),
        .aluOutput_in(aluOutput_in), .writeData_in(writeData_in),
        .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn), .mem_Rd(mem_Rd), .mem_Wr(mem_Wr),
        .mem_createdump(mem_createdump), .mem_DataOut(mem_DataOut), .mem_Done(mem_Done),
        .mem_err(mem_err), .readData_out(readData_out), .memStall(memStall),
        .latch_en(latch_en), .err(err), .stall_count(stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_in();
        rst = 0; valid_in = 0; DMemEn_in = 0; MemWrite_in = 0; DMemDump_in = 0;
        aluOutput_in = 16'h0; writeData_in = 16'h0; mem_DataOut = 16'h0;
        mem_Done = 0; mem_err = 0;
    endtask

    task automatic access(input bit w, input logic [15:0] a, input logic [15:0] d);
        valid_in = 1; DMemEn_in = 1; DMemDump_in = 0; MemWrite_in = w;
        aluOutput_in = a; writeData_in = d;
    endtask

    // Inputs are already driven (just after a falling edge); check this cycle,
    // advance the model, and return at the next falling edge.
    task automatic cyc();
        bit e_rd, e_wr, e_cd, e_st, req, fin;
        bit [15:0] e_rdout;
        #1;
        e_rd = 0; e_wr = 0; e_cd = 0; e_st = 0; e_rdout = m_rdreg; fin = 0;
        req = valid_in & DMemEn_in & ~DMemDump_in;
        if (!rst) begin
            if (m_dead) e_st = 1;
            else if (m_busy) begin
                e_rd = !m_pw; e_wr = m_pw; e_st = !mem_Done;
                if (mem_Done && !mem_err && !m_pw) e_rdout = mem_DataOut;
            end else if (valid_in && DMemDump_in) e_cd = 1;
            else if (req) begin
                e_st = !mem_Done;
                if (!aluOutput_in[0]) begin
                    e_rd = !MemWrite_in; e_wr = MemWrite_in;
                    if (mem_Done && !mem_err && !MemWrite_in) e_rdout = mem_DataOut;
                end
            end
        end
        chk("mem_Rd", mem_Rd, e_rd);
        chk("mem_Wr", mem_Wr, e_wr);
        chk("createdump", mem_createdump, e_cd);
        chk("memStall", memStall, e_st);
        chk("latch_en", latch_en, !e_st);
        chk("err", err, m_err);
        chk("stall_count", stall_count, m_cnt);
        chk("readData", readData_out, e_rdout);
        chk("mem_Addr", mem_Addr, aluOutput_in);
        chk("mem_DataIn", mem_DataIn, writeData_in);

        if (rst) begin
            m_busy = 0; m_dead = 0; m_err = 0; m_cnt = 0; m_rdreg = 0; m_waited = 0;
        end else begin
            if (e_st && m_cnt < 65535) m_cnt++;
            m_rdreg = e_rdout;
            if (m_dead) fin = 0;
            else if (m_busy) begin
                if (mem_err) fin = 1;
                else if (mem_Done) m_busy = 0;
                else begin
                    m_waited++;
                    if (m_waited >= 255) fin = 1;
                end
            end else if (valid_in && DMemDump_in) m_dead = 1;
            else if (req) begin
                if (aluOutput_in[0] || mem_err) fin = 1;
                else if (!mem_Done) begin
                    m_busy = 1; m_pw = MemWrite_in; m_waited = 0;
                end
            end
            if (fin) begin m_err = 1; m_dead = 1; m_busy = 0; end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_in(); rst = 1; cyc(); rst = 0;
    endtask

    initial begin
        idle_in();
        m_busy = 0; m_dead = 0; m_pw = 0; m_err = 0; m_waited = 0; m_cnt = 0; m_rdreg = 0;
        @(negedge clk);
        rst = 1; cyc(); cyc(); rst = 0;
        #1;
        chk("rst_err", err, 0);
        chk("rst_cnt", stall_count, 0);
        chk("rst_rd", readData_out, 0);
        chk("rst_latch", latch_en, 1);

        // 0-wait load hit
        access(0, 16'h0010, 16'h0); mem_Done = 1; mem_DataOut = 16'hBEEF; #1;
        chk("hit_rd", readData_out, 16'hBEEF);
        chk("hit_stall", memStall, 0);
        cyc();
        idle_in(); mem_Done = 1; mem_DataOut = 16'h5555; cyc();   // stray done ignored
        chk("hit_hold", readData_out, 16'hBEEF);

        // store with 3 wait cycles
        do_reset();
        access(1, 16'h0020, 16'h1234);
        for (int i = 0; i < 4; i++) begin
            mem_Done = (i == 3); #1;
            chk("st_wr", mem_Wr, 1);
            cyc();
        end
        idle_in(); #1;
        chk("st_cnt", stall_count, 3);
        cyc();

        // misaligned load traps
        access(0, 16'h0011, 16'h0); #1;
        chk("mis_rd", mem_Rd, 0);
        cyc();
        idle_in(); #1;
        chk("mis_err", err, 1);
        for (int i = 0; i < 4; i++) begin access(0, 16'h0040, 0); mem_Done = 1; cyc(); end

        // HALT
        do_reset();
        idle_in(); valid_in = 1; DMemDump_in = 1; #1;
        chk("halt_cd", mem_createdump, 1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            access(0, 16'h0040, 0); #1;
            chk("halt_cd0", mem_createdump, 0);
            chk("halt_rd0", mem_Rd, 0);
            cyc();
        end

        // watchdog
        do_reset();
        access(0, 16'h0080, 0); cyc();
        for (int i = 0; i < 255; i++) begin
            #1; if (i == 254) chk("wd_pre", err, 0);
            cyc();
        end
        #1; chk("wd_err", err, 1);
        cyc();

        // reset mid-WAIT
        do_reset();
        access(0, 16'h0100, 0); cyc(); cyc();
        rst = 1; #1;
        chk("rstw_rd", mem_Rd, 0);
        chk("rstw_stall", memStall, 0);
        cyc();
        idle_in(); #1;
        chk("rstw_cnt", stall_count, 0);
        chk("rstw_rd2", mem_Rd, 0);
        cyc();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(99) < 3);
            valid_in     = ($urandom_range(99) < 75);
            DMemEn_in    = ($urandom_range(99) < 70);
            MemWrite_in  = $urandom_range(1);
            DMemDump_in  = ($urandom_range(99) < 2);
            aluOutput_in = 16'($urandom) & (($urandom_range(99) < 8) ? 16'hFFFF : 16'hFFFE);
            writeData_in = 16'($urandom);
            mem_DataOut  = 16'($urandom);
            mem_Done     = ($urandom_range(99) < 45);
            mem_err      = ($urandom_range(99) < 2);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
